// File: rtl/sram_pkg.sv
// Shared definitions for the multi-port asynchronous SRAM controller:
// FSM state codes, wait-counter width and width helpers.
package sram_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD       = 3'd1;
  localparam logic [2:0] WR_SETUP = 3'd2;
  localparam logic [2:0] WR       = 3'd3;
  localparam logic [2:0] ACK      = 3'd4;

  localparam int WAIT_W = 4;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // A single-port build still needs a 1-bit grant index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above 'last', wrapping
// to the lowest index. The last-grant register lives in the parent.
module rr_arbiter
  import sram_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          vld
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    vld     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!vld && req[i] && (i > int'(last))) begin
        vld        = 1'b1;
        gnt[i]     = 1'b1;
        gnt_idx    = IW'(i);
      end
    end
    // Nothing above the last grant: wrap around to the bottom.
    for (int i = 0; i < N; i++) begin
      if (!vld && req[i]) begin
        vld        = 1'b1;
        gnt[i]     = 1'b1;
        gnt_idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/sram_multiport_ctrl.sv
// N-port round-robin controller for one asynchronous SRAM bank with
// programmable read/write wait states; every output comes from a flop.
module sram_multiport_ctrl
  import sram_pkg::*;
#(
  parameter  int N_MASTERS = 2,
  parameter  int ADDR_W    = 20,
  parameter  int DATA_W    = 32,
  parameter  int RD_WAIT   = 1,
  parameter  int WR_WAIT   = 1,
  localparam int BE_W      = be_w(DATA_W)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        m_req,
  input  logic [N_MASTERS-1:0]        m_wr,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*BE_W-1:0]   m_be_n,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  output logic [N_MASTERS-1:0]        m_ack,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [BE_W-1:0]             ram_be_n,
  output logic                        ram_ce_n,
  output logic                        ram_oe_n,
  output logic                        ram_we_n,
  output logic [DATA_W-1:0]           ram_data_out,
  output logic                        ram_data_oe,
  input  logic [DATA_W-1:0]           ram_data_in
);

  localparam int IW = idx_w(N_MASTERS);

  logic [2:0]           state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [IW-1:0]        rr_last_q, rr_last_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic                 wr_q, wr_d;
  logic [N_MASTERS-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BE_W-1:0]      be_n_q, be_n_d;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic                 ce_n_q, ce_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 we_n_q, we_n_d;
  logic                 doe_q, doe_d;

  logic [N_MASTERS-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_vld;

  logic                 sel_wr;
  logic [ADDR_W-1:0]    sel_addr;
  logic [BE_W-1:0]      sel_be_n;
  logic [DATA_W-1:0]    sel_wdata;

  rr_arbiter #(.N(N_MASTERS)) u_arb (
    .req     (m_req),
    .last    (rr_last_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .vld     (arb_vld)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_be_n  = '1;
    sel_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (arb_gnt[i]) begin
        sel_wr    = m_wr[i];
        sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        sel_be_n  = m_be_n[i*BE_W +: BE_W];
        sel_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    rr_last_d = rr_last_q;
    gnt_d     = gnt_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    be_n_d    = be_n_q;
    dout_d    = dout_q;

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          rr_last_d = arb_idx;
          gnt_d     = arb_gnt;
          wr_d      = sel_wr;
          addr_d    = sel_addr;
          be_n_d    = sel_be_n;
          dout_d    = sel_wdata;
          wait_d    = WAIT_W'(RD_WAIT);
          state_d   = sel_wr ? WR_SETUP : RD;
        end
      end
      RD: begin
        if (wait_q == '0) begin
          rdata_d = ram_data_in;
          state_d = ACK;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      WR_SETUP: begin
        wait_d  = WAIT_W'(WR_WAIT);
        state_d = WR;
      end
      WR: begin
        if (wait_q == '0) state_d = ACK;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so they flop in with it.
    ce_n_d = !((state_d == RD) || (state_d == WR_SETUP) || (state_d == WR));
    oe_n_d = (state_d != RD);
    we_n_d = (state_d != WR);
    doe_d  = (state_d == WR_SETUP) || (state_d == WR) || ((state_d == ACK) && wr_d);
    ack_d  = (state_d == ACK) ? gnt_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      rr_last_q <= IW'(N_MASTERS - 1);
      gnt_q     <= '0;
      wr_q      <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      be_n_q    <= '1;
      dout_q    <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      doe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      rr_last_q <= rr_last_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      be_n_q    <= be_n_d;
      dout_q    <= dout_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      doe_q     <= doe_d;
    end
  end

  assign m_ack        = ack_q;
  assign m_rdata      = rdata_q;
  assign ram_addr     = addr_q;
  assign ram_be_n     = be_n_q;
  assign ram_ce_n     = ce_n_q;
  assign ram_oe_n     = oe_n_q;
  assign ram_we_n     = we_n_q;
  assign ram_data_out = dout_q;
  assign ram_data_oe  = doe_q;

endmodule

// File: doc/sram_multiport_ctrl.md
Name: sram_multiport_ctrl

Overview:
Parametrised successor to the single-master SRAM controller (req/wr/data_ok handshake).
- Serves N_MASTERS independent request ports onto one asynchronous SRAM bank (BaseRAM or ExtRAM).
- Round-robin arbitration between ports.
- Configurable read and write wait states.
- Owns the bank's tri-state data bus via separate out/oe/in signals; the top level only instantiates the IOBUF.

Parameters:
N_MASTERS, 2, number of request ports (1..8)
ADDR_W, 20, SRAM word address width
DATA_W, 32, data width; BE_W = DATA_W/8
RD_WAIT, 1, extra cycles oe_n is held low before read data is sampled (0..15)
WR_WAIT, 1, extra cycles we_n is held low (0..15)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
m_req  in  N_MASTERS  per-port request; held stable until that port's ack
m_wr  in  N_MASTERS  1 = write, 0 = read
m_addr  in  N_MASTERS*ADDR_W  port i occupies slice [i*ADDR_W +: ADDR_W]
m_be_n  in  N_MASTERS*BE_W  byte enables, active low
m_wdata  in  N_MASTERS*DATA_W  write data
m_ack  out  N_MASTERS  one-cycle completion pulse, one-hot
m_rdata  out  DATA_W  read data, valid while the owning ack is high
ram_addr  out  ADDR_W  SRAM address
ram_be_n  out  BE_W  SRAM byte enables
ram_ce_n  out  1  chip enable, active low
ram_oe_n  out  1  output enable, active low
ram_we_n  out  1  write enable, active low
ram_data_out  out  DATA_W  data driven to the pad
ram_data_oe  out  1  pad driver enable
ram_data_in  in  DATA_W  data sampled from the pad

Behaviour:
- All outputs are registered.
- Reset values: m_ack=0, m_rdata=0, ram_addr=0, ram_be_n=all 1, ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_data_out=0, ram_data_oe=0, state=IDLE, rr_last=N_MASTERS-1 (port 0 has first priority).
- IDLE: if any m_req is high, the arbiter picks the first requesting port searching from rr_last+1 upward with wrap-around. At the edge:
  - latch the selected port's addr, be_n, wdata and wr;
  - rr_last <= granted port;
  - next state is RD if wr=0, WR_SETUP if wr=1.
  - If no request is high, all strobes stay deasserted.
- RD: ce_n=0, oe_n=0, addr and be_n driven, data_oe=0. Lasts RD_WAIT+1 cycles; a wait counter counts down. On the final edge, ram_data_in is captured into m_rdata and the state moves to ACK.
- WR_SETUP: one cycle with ce_n=0, oe_n=1, we_n=1, data_oe=1, addr/be_n/data driven. Next state is WR.
- WR: we_n=0 for WR_WAIT+1 cycles; addr, be_n and data held. Next state is ACK.
- ACK: one cycle.
  - m_ack[granted]=1.
  - we_n=1 and oe_n=1; ce_n=1.
  - data_oe stays 1 after a write (hold time) and is 0 after a read; it returns to 0 at the end of ACK.
  - Next state is IDLE unconditionally.
- Latency from IDLE sampling a request to the ack cycle: read = RD_WAIT+2 cycles; write = WR_WAIT+3 cycles.
- Throughput: one transaction per (latency+1) cycles. IDLE is always visited between transactions.
- Master contract: drop m_req (or present a new request) at the edge that ends the ack cycle. A request still high in IDLE is treated as a new transaction.
- m_rdata holds its last value until the next read completes. Writes never modify it.
- Fairness: with all ports requesting continuously, grants rotate 0,1,..,N-1,0. No port waits more than N_MASTERS-1 transactions.
- Requests arriving from non-granted ports mid-transaction are ignored until IDLE.
- A port whose req changes before its ack is a protocol violation; the latched values are used.
- Reset mid-transaction: asynchronously force all outputs to their reset values. The in-flight transaction is abandoned with no ack, and rr_last returns to N_MASTERS-1.
- ram_oe_n and ram_we_n are never both low. ram_data_oe is never 1 while ram_oe_n=0.

Decomposition:
- Shared package sram_pkg: state enum (IDLE, RD, WR_SETUP, WR, ACK); localparams BE_W and WAIT_W=4; function for grant-index width ($clog2(N_MASTERS), minimum 1).
- Sub-module rr_arbiter (parameter N): inputs req vector and last index; outputs one-hot grant, grant index and valid. Purely combinational; rr_last is held in the parent.

Test Plan:
- Single read, RD_WAIT=1: memory model has 0xDEADBEEF at address 0x00010; port 0 reads it -> oe_n low for exactly 2 cycles, m_ack[0] pulses 3 cycles after the request is sampled, m_rdata=0xDEADBEEF.
- Byte write, WR_WAIT=1: port 1 writes 0x000000AB with be_n=4'b1110 to 0x00020 -> sequence is setup 1 cycle, we_n low 2 cycles, ack, with data_oe high through the ack cycle; model word's low byte becomes 0xAB and other bytes are unchanged.
- Round-robin, N_MASTERS=3: all ports request reads continuously -> ack order is 0,1,2,0,1,2 with no port starved.
- Simultaneous write then read to the same address: port 0 writes 0x12345678 and port 1 reads the same address in the same cycle -> write is granted first, read returns 0x12345678.
- Wait-state sweep: RD_WAIT=0 and 3 -> oe_n low for 1 and 4 cycles respectively, and ack latency is 2 and 5 cycles.
- Reset asserted during WR -> we_n, ce_n and data_oe deassert in the same cycle with no ack; after release, port 0 is granted first.
